// File: rtl/quad_pkg.sv
// quad_pkg: shared FSM/delta types and quadrature helpers for quad_step_decoder
// Contents: qd_state_t (INIT/TRACK), qd_delta_t, qd_idx (AB -> Gray position), qd_classify (position delta)
package quad_pkg;
    localparam logic [0:0] ST_INIT  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;
    typedef enum logic [0:0] {INIT = ST_INIT, TRACK = ST_TRACK} qd_state_t;
    typedef enum logic [1:0] {DELTA_NONE, DELTA_FWD, DELTA_REV, DELTA_BAD} qd_delta_t;
    // AB 00->0, 01->1, 11->2, 10->3 so forward motion is +1 mod 4
    function automatic logic [1:0] qd_idx(input logic a, input logic b);
        return {a, a ^ b};
    endfunction
    function automatic qd_delta_t qd_classify(input logic [1:0] old_idx, input logic [1:0] new_idx);
        logic [1:0] d;
        d = new_idx - old_idx;
        return d == 2'd0 ? DELTA_NONE : d == 2'd1 ? DELTA_FWD : d == 2'd3 ? DELTA_REV : DELTA_BAD;
    endfunction
endpackage

// File: rtl/debounce_filter.sv
// debounce_filter: per-channel stability filter with a direct-load bypass
// Ports: clk, rst (sync, active-high), load (f follows s, counter cleared), s (synchronised in), f (filtered out)
module debounce_filter #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic s,
    output logic f
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    logic [CW-1:0] cnt;
    // a match, a load, or the last mismatch of a full run all end with f==s and a cleared counter
    always_ff @(posedge clk)
        if (rst) begin
            f   <= 1'b0;
            cnt <= '0;
        end else if (load || s == f || cnt == CW'(DEB_CYCLES - 1)) begin
            f   <= s;
            cnt <= '0;
        end else
            cnt <= cnt + 1'b1;
endmodule

// File: rtl/quad_step_decoder.sv
// quad_step_decoder: quadrature encoder to 1-cycle step pulse + direction
// Ports: clk, rst (sync, active-high), en (1=emit steps/errors), enc_a/enc_b (raw async channels),
//        step (1-cycle pulse per detent), dir (1=up, holds last step direction), err (1-cycle illegal transition)
module quad_step_decoder
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES      = 2,
    parameter int DEB_CYCLES       = 4,
    parameter int STEPS_PER_DETENT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic enc_a,
    input  logic enc_b,
    output logic step,
    output logic dir,
    output logic err
);
    localparam int IW = $clog2(SYNC_STAGES + DEB_CYCLES + 1);
    localparam logic signed [3:0] ACC_MAX = 4'(STEPS_PER_DETENT - 1);
    localparam logic signed [3:0] ACC_MIN = -ACC_MAX;
    logic [SYNC_STAGES-1:0] sync_a, sync_b;
    logic                   sa, sb, fa, fb, init;
    logic [IW-1:0]          init_cnt;
    qd_state_t              state;
    logic [1:0]             idx_old, idx_new;
    qd_delta_t              delta;
    logic signed [3:0]      acc;
    assign sa      = sync_a[SYNC_STAGES-1];
    assign sb      = sync_b[SYNC_STAGES-1];
    assign init    = state == INIT;
    assign idx_new = qd_idx(fa, fb);
    assign delta   = qd_classify(idx_old, idx_new);
    always_ff @(posedge clk)
        if (rst) begin
            sync_a <= '0;
            sync_b <= '0;
        end else begin
            sync_a <= {sync_a[SYNC_STAGES-2:0], enc_a};
            sync_b <= {sync_b[SYNC_STAGES-2:0], enc_b};
        end
    debounce_filter #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (.clk(clk), .rst(rst), .load(init), .s(sa), .f(fa));
    debounce_filter #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (.clk(clk), .rst(rst), .load(init), .s(sb), .f(fb));
    // INIT spans the synchroniser fill plus one debounce window, so any resting position is absorbed silently
    always_ff @(posedge clk)
        if (rst) begin
            state    <= INIT;
            init_cnt <= '0;
        end else if (init) begin
            init_cnt <= init_cnt + 1'b1;
            if (init_cnt == IW'(SYNC_STAGES + DEB_CYCLES - 1))
                state <= TRACK;
        end
    // during INIT idx_old tracks the value the filters are loading, so TRACK starts with delta NONE
    always_ff @(posedge clk)
        if (rst) begin
            idx_old <= '0;
            acc     <= '0;
            step    <= 1'b0;
            err     <= 1'b0;
            dir     <= 1'b1;
        end else begin
            idx_old <= init ? qd_idx(sa, sb) : idx_new;
            step    <= 1'b0;
            err     <= 1'b0;
            if (init || !en)
                acc <= '0;
            else
                case (delta)
                    DELTA_FWD:
                        if (acc == ACC_MAX) begin
                            step <= 1'b1;
                            dir  <= 1'b1;
                            acc  <= '0;
                        end else
                            acc <= acc + 4'sd1;
                    DELTA_REV:
                        if (acc == ACC_MIN) begin
                            step <= 1'b1;
                            dir  <= 1'b0;
                            acc  <= '0;
                        end else
                            acc <= acc - 4'sd1;
                    DELTA_BAD: begin
                        err <= 1'b1;
                        acc <= '0;
                    end
                    default: ;
                endcase
        end
endmodule

// File: tb/tb_quad_step_decoder.sv
// tb_quad_step_decoder: table-driven phases plus random stimulus against a history-based reference model
`timescale 1ns/1ps
module tb_quad_step_decoder;
    import quad_pkg::*;
    localparam int SYNC = 2, DEB = 4, SPD = 4;
    logic clk = 1'b0, rst = 1'b1, en = 1'b1, enc_a = 1'b0, enc_b = 1'b0;
    logic step, dir, err;
    quad_step_decoder #(.SYNC_STAGES(SYNC), .DEB_CYCLES(DEB), .STEPS_PER_DETENT(SPD)) dut (
        .clk(clk), .rst(rst), .en(en), .enc_a(enc_a), .enc_b(enc_b),
        .step(step), .dir(dir), .err(err)
    );
    always #5 clk = ~clk;
    typedef struct {
        bit r; bit a; bit b; bit e;
        int hold; int steps; int errs; bit d; int at;
    } vec_t;
    vec_t tbl[$];
    int vectors = 0, miscompares = 0, cyc = 0;
    // reference model: raw delay line, filtered values from recent sample history, integer position/accumulator
    bit qa[$], qb[$], ha[$], hb[$];
    bit m_fa, m_fb, m_step, m_err, m_dir;
    int m_old, m_acc, m_init;
    function automatic bit run_differs(input bit h[$], input bit f);
        if (h.size() < DEB) return 1'b0;
        for (int i = h.size() - DEB; i < h.size(); i++)
            if (h[i] == f) return 1'b0;
        return 1'b1;
    endfunction
    task automatic model_edge(input bit r, input bit a, input bit b, input bit e);
        bit sa, sb;
        int idx, d;
        if (r) begin
            qa.delete(); qb.delete(); ha.delete(); hb.delete();
            for (int i = 0; i < SYNC; i++) begin
                qa.push_back(1'b0);
                qb.push_back(1'b0);
            end
            m_fa = 0; m_fb = 0; m_old = 0; m_acc = 0; m_init = SYNC + DEB;
            m_step = 0; m_err = 0; m_dir = 1;
            return;
        end
        sa = qa[SYNC-1];
        sb = qb[SYNC-1];
        m_step = 0;
        m_err = 0;
        if (m_init > 0) begin
            m_init--;
            m_acc = 0;
            m_fa = sa;
            m_fb = sb;
            m_old = 2 * sa + (sa ^ sb);
            ha.delete(); hb.delete();
        end else begin
            idx = 2 * m_fa + (m_fa ^ m_fb);
            d = (idx - m_old + 4) % 4;
            m_old = idx;
            if (!e) m_acc = 0;
            else if (d == 2) begin
                m_err = 1;
                m_acc = 0;
            end else if (d != 0) begin
                m_acc += (d == 1) ? 1 : -1;
                if (m_acc == SPD || m_acc == -SPD) begin
                    m_step = 1;
                    m_dir = m_acc > 0;
                    m_acc = 0;
                end
            end
            ha.push_back(sa); if (ha.size() > DEB) void'(ha.pop_front());
            hb.push_back(sb); if (hb.size() > DEB) void'(hb.pop_front());
            if (run_differs(ha, m_fa)) begin m_fa = sa; ha.delete(); end
            if (run_differs(hb, m_fb)) begin m_fb = sb; hb.delete(); end
        end
        qa.push_front(a); void'(qa.pop_back());
        qb.push_front(b); void'(qb.pop_back());
    endtask
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
        end
    endtask
    task automatic tick(input bit r, input bit a, input bit b, input bit e);
        rst = r; enc_a = a; enc_b = b; en = e;
        @(posedge clk);
        model_edge(r, a, b, e);
        #1;
        cyc++;
        chk("step", step, m_step);
        chk("err", err, m_err);
        chk("dir", dir, m_dir);
        chk("state", dut.state == TRACK, m_init == 0);
    endtask
    task automatic run_phase(input vec_t v, input int n);
        int steps = 0, errs = 0, first = 0;
        for (int i = 1; i <= v.hold; i++) begin
            tick(v.r, v.a, v.b, v.e);
            if ((step === 1'b1 || err === 1'b1) && first == 0) first = i;
            steps += int'(step === 1'b1);
            errs += int'(err === 1'b1);
        end
        chk($sformatf("phase%0d_steps", n), steps, v.steps);
        chk($sformatf("phase%0d_errs", n), errs, v.errs);
        chk($sformatf("phase%0d_dir", n), dir, v.d);
        if (v.at != 0) chk($sformatf("phase%0d_latency", n), first, v.at);
    endtask
    function automatic void add(bit r, bit a, bit b, bit e, int hold, int steps, int errs, bit d, int at);
        tbl.push_back('{r, a, b, e, hold, steps, errs, d, at});
    endfunction
    initial begin
        // reset, then quiet 00
        add(1, 0, 0, 1, 3, 0, 0, 1, 0);
        add(0, 0, 0, 1, 20, 0, 0, 1, 0);
        // forward detent, then reverse detent
        add(0, 0, 1, 1, 10, 0, 0, 1, 0);
        add(0, 1, 1, 1, 10, 0, 0, 1, 0);
        add(0, 1, 0, 1, 10, 0, 0, 1, 0);
        add(0, 0, 0, 1, 10, 1, 0, 1, 7);
        add(0, 1, 0, 1, 10, 0, 0, 1, 0);
        add(0, 1, 1, 1, 10, 0, 0, 1, 0);
        add(0, 0, 1, 1, 10, 0, 0, 1, 0);
        add(0, 0, 0, 1, 10, 1, 0, 0, 7);
        // short glitch and chatter on A
        add(0, 1, 0, 1, 3, 0, 0, 0, 0);
        add(0, 0, 0, 1, 10, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            add(0, 1, 0, 1, 2, 0, 0, 0, 0);
            add(0, 0, 0, 1, 2, 0, 0, 0, 0);
        end
        add(0, 0, 0, 1, 10, 0, 0, 0, 0);
        // both channels at once, then a forward detent
        add(0, 1, 1, 1, 10, 0, 1, 0, 7);
        add(0, 1, 0, 1, 10, 0, 0, 0, 0);
        add(0, 0, 0, 1, 10, 0, 0, 0, 0);
        add(0, 0, 1, 1, 10, 0, 0, 0, 0);
        add(0, 1, 1, 1, 10, 1, 0, 1, 7);
        // half detent out and back, detent with en=0, detent with en=1
        add(0, 1, 0, 1, 10, 0, 0, 1, 0);
        add(0, 0, 0, 1, 10, 0, 0, 1, 0);
        add(0, 1, 0, 1, 10, 0, 0, 1, 0);
        add(0, 1, 1, 1, 10, 0, 0, 1, 0);
        add(0, 1, 0, 0, 10, 0, 0, 1, 0);
        add(0, 0, 0, 0, 10, 0, 0, 1, 0);
        add(0, 0, 1, 0, 10, 0, 0, 1, 0);
        add(0, 1, 1, 0, 10, 0, 0, 1, 0);
        add(0, 1, 0, 1, 10, 0, 0, 1, 0);
        add(0, 0, 0, 1, 10, 0, 0, 1, 0);
        add(0, 0, 1, 1, 10, 0, 0, 1, 0);
        add(0, 1, 1, 1, 10, 1, 0, 1, 7);
        // clear acc via BAD, climb to +2 at AB=11, reset there, then a detent
        add(0, 0, 0, 1, 10, 0, 1, 1, 7);
        add(0, 0, 1, 1, 10, 0, 0, 1, 0);
        add(0, 1, 1, 1, 10, 0, 0, 1, 0);
        add(1, 1, 1, 1, 5, 0, 0, 1, 0);
        add(0, 1, 1, 1, 10, 0, 0, 1, 0);
        add(0, 1, 0, 1, 10, 0, 0, 1, 0);
        add(0, 0, 0, 1, 10, 0, 0, 1, 0);
        add(0, 0, 1, 1, 10, 0, 0, 1, 0);
        add(0, 1, 1, 1, 10, 1, 0, 1, 7);
        for (int i = 0; i < tbl.size(); i++) run_phase(tbl[i], i);
        for (int i = 0; i < 250; i++) begin
            bit r, a, b, e;
            int hold;
            r = $urandom_range(0, 39) == 0;
            a = 1'($urandom_range(0, 1));
            b = 1'($urandom_range(0, 1));
            e = $urandom_range(0, 7) != 0;
            hold = $urandom_range(1, 12);
            for (int j = 0; j < hold; j++) tick(r, a, b, e);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
